// File: rtl/controller.sv
// Game controller FSM: sequences setup, FPGA playback, user entry, checking,
// round advance and result display. Moore outputs decode the state register.
// Optional feature: define ENTER_EDGE_EN to synchronize `enter` and act only on
// its rising edge; otherwise the raw `enter` level is used directly.

package controller_pkg;
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    SETUP     = 3'd1,
    PLAY_FPGA = 3'd2,
    PLAY_USER = 3'd3,
    CHECK     = 3'd4,
    NEXT_RND  = 3'd5,
    RESULT    = 3'd6
  } state_t;
endpackage

module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       R,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  state_t state;
  state_t state_nxt;
  logic   enter_q;

`ifdef ENTER_EDGE_EN
  logic enter_s1;
  logic enter_s2;
  logic enter_prev;
  logic enter_pulse;

  // Two-flop synchronizer followed by a registered rising-edge pulse
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      enter_s1    <= 1'b0;
      enter_s2    <= 1'b0;
      enter_prev  <= 1'b0;
      enter_pulse <= 1'b0;
    end else begin
      enter_s1    <= enter;
      enter_s2    <= enter_s1;
      enter_prev  <= enter_s2;
      enter_pulse <= enter_s2 & ~enter_prev;
    end
  end

  assign enter_q = enter_pulse;
`else
  assign enter_q = enter;
`endif

  // State register with asynchronous abort to INIT
  always_ff @(posedge clk or posedge R) begin
    if (R) state <= INIT;
    else   state <= state_nxt;
  end

  // Next-state logic; unused code 7 falls back to INIT
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      state_nxt = SETUP;
      SETUP:     if (enter_q) state_nxt = PLAY_FPGA;
      PLAY_FPGA: if (end_FPGA) state_nxt = PLAY_USER;
      PLAY_USER: begin
        if (end_time)      state_nxt = RESULT;
        else if (end_User) state_nxt = CHECK;
      end
      CHECK: begin
        if (match && !win) state_nxt = NEXT_RND;
        else               state_nxt = RESULT;
      end
      NEXT_RND:  state_nxt = PLAY_FPGA;
      RESULT:    if (enter_q) state_nxt = INIT;
      default:   state_nxt = INIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b0;
    case (state)
      INIT: begin
        R1  = 1'b1;
        R2  = 1'b1;
        SEL = 1'b1;
      end
      SETUP: begin
        E1  = 1'b1;
        SEL = 1'b1;
      end
      PLAY_FPGA: begin
        E3  = 1'b1;
        SEL = 1'b1;
      end
      PLAY_USER: begin
        E2  = 1'b1;
        SEL = 1'b1;
      end
      CHECK:     SEL = 1'b1;
      NEXT_RND: begin
        E4  = 1'b1;
        R2  = 1'b1;
        SEL = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the game controller FSM.
// Works with or without ENTER_EDGE_EN; enter latency expectations adapt.

module tb_controller;
  import controller_pkg::*;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       enter = 1'b0;
  logic       end_FPGA = 1'b0;
  logic       end_User = 1'b0;
  logic       end_time = 1'b0;
  logic       win = 1'b0;
  logic       match = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state_o;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

`ifdef ENTER_EDGE_EN
  localparam int unsigned ENTER_LAT = 4;
`else
  localparam int unsigned ENTER_LAT = 1;
`endif

  // {R1,R2,E1,E2,E3,E4,SEL} per state
  localparam logic [6:0] O_INIT  = 7'b1100001;
  localparam logic [6:0] O_SETUP = 7'b0010001;
  localparam logic [6:0] O_FPGA  = 7'b0000101;
  localparam logic [6:0] O_USER  = 7'b0001001;
  localparam logic [6:0] O_CHECK = 7'b0000001;
  localparam logic [6:0] O_NEXT  = 7'b0100011;
  localparam logic [6:0] O_RES   = 7'b0000000;

  controller dut (
    .clk      (clk),
    .R        (R),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state_o  (state_o)
  );

  assign outs = {R1, R2, E1, E2, E3, E4, SEL};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] st, input logic [6:0] o);
    check({tag, "_state"}, {5'd0, state_o}, {5'd0, st});
    check({tag, "_outs"}, {1'b0, outs}, {1'b0, o});
  endtask

  // One clock edge, then sample 1 time unit later and check enable one-hot-or-zero
  task automatic step();
    @(posedge clk);
    #1;
    check("e_onehot0", {7'd0, $onehot0({E1, E2, E3, E4})}, 8'd1);
  endtask

  // Present enter for one edge, then wait until the FSM has consumed it
  task automatic enter_hit();
    enter = 1'b1;
    step();
    enter = 1'b0;
    for (int unsigned i = 1; i < ENTER_LAT; i++) step();
  endtask

  initial begin
    logic [2:0] seen [10];
    logic [2:0] exp_res [6];
    int unsigned first_play;
    int unsigned n_trans;

`ifdef ENTER_EDGE_EN
    exp_res = '{3'd6, 3'd6, 3'd6, 3'd0, 3'd1, 3'd1};
`else
    exp_res = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
`endif

    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check_st("reset", 3'd0, O_INIT);
    R = 1'b0;
    step();
    check_st("after_reset", 3'd1, O_SETUP);

    // Enter held 10 cycles in SETUP: exactly one advance
    enter = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      seen[i] = state_o;
    end
    enter = 1'b0;
    first_play = 0;
    n_trans = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (seen[i] == 3'd2 && (i == 0 || seen[i-1] == 3'd1)) begin
        n_trans++;
        if (first_play == 0) first_play = i + 1;
      end
    end
    check("setup_trans_count", n_trans[7:0], 8'd1);
    check("setup_latency", first_play[7:0], ENTER_LAT[7:0]);
    check_st("held_play_fpga", 3'd2, O_FPGA);

    // Full round: match, no win
    end_FPGA = 1'b1;
    step();
    check_st("round_user", 3'd3, O_USER);
    end_FPGA = 1'b0;
    enter = 1'b1;
    end_User = 1'b1; match = 1'b1; win = 1'b0;
    step();
    enter = 1'b0;
    check_st("round_check", 3'd4, O_CHECK);
    end_User = 1'b0;
    step();
    check_st("round_next", 3'd5, O_NEXT);
    step();
    check_st("round_back_fpga", 3'd2, O_FPGA);

    // end_time and end_User together: timeout wins
    end_FPGA = 1'b1;
    step();
    end_FPGA = 1'b0;
    check_st("tie_user", 3'd3, O_USER);
    end_time = 1'b1; end_User = 1'b1;
    step();
    end_time = 1'b0; end_User = 1'b0;
    check_st("tie_result", 3'd6, O_RES);
    step();
    check_st("result_hold", 3'd6, O_RES);

    // Enter held in RESULT
    enter = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      check("res_hold_seq", {5'd0, state_o}, {5'd0, exp_res[i]});
    end
    enter = 1'b0;
`ifdef ENTER_EDGE_EN
    enter_hit();
`endif
    check_st("res_to_play", 3'd2, O_FPGA);

    // CHECK with match=0 -> RESULT
    end_FPGA = 1'b1;
    step();
    end_FPGA = 1'b0;
    end_User = 1'b1; match = 1'b0; win = 1'b0;
    step();
    end_User = 1'b0;
    check_st("nomatch_check", 3'd4, O_CHECK);
    step();
    check_st("nomatch_result", 3'd6, O_RES);

    // Back to PLAY_FPGA via enter, then CHECK with match=1 win=1 -> RESULT
    enter_hit();
    check_st("restart_init", 3'd0, O_INIT);
    step();
    check_st("restart_setup", 3'd1, O_SETUP);
    enter_hit();
    check_st("restart_play", 3'd2, O_FPGA);
    end_FPGA = 1'b1;
    step();
    end_FPGA = 1'b0;
    end_User = 1'b1; match = 1'b1; win = 1'b1;
    step();
    end_User = 1'b0;
    check_st("win_check", 3'd4, O_CHECK);
    step();
    check_st("win_result", 3'd6, O_RES);

    // Async reset mid-PLAY_FPGA, between edges
    enter_hit();
    step();
    enter_hit();
    check_st("pre_abort_play", 3'd2, O_FPGA);
    #2;
    R = 1'b1;
    #1;
    check_st("async_abort", 3'd0, O_INIT);
    step();
    check_st("abort_held", 3'd0, O_INIT);
    R = 1'b0;
    step();
    check_st("abort_release", 3'd1, O_SETUP);

    // Backdoor illegal code 7 recovers to INIT
    force dut.state = state_t'(3'd7);
    #1;
    release dut.state;
    #1;
    check("illegal_code", {5'd0, state_o}, 8'd7);
    step();
    check_st("illegal_recover", 3'd0, O_INIT);
    step();
    check_st("illegal_setup", 3'd1, O_SETUP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
